// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - circular FIFO controller driving a 64x16 single-port RAM
module ram_fifo_ctrl #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop_req,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] ram_add,
  output logic [DW-1:0] ram_in,
  output logic          ram_read,
  output logic          ram_write,
  output logic          ram_en,
  input  logic [DW-1:0] ram_out
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t        state, next_state;
  logic [AW-1:0] wr_ptr, rd_ptr, add_q;
  logic [DW-1:0] in_q;
  logic          do_pop, do_push;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

  // Pop wins the single RAM port; strobes are held off while in reset.
  assign do_pop     = (state == IDLE) && pop_req && !empty && !rst;
  assign push_ready = (state == IDLE) && !full && !(pop_req && !empty) && !rst;
  assign do_push    = push_ready && push_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      add_q  <= '0;
      in_q   <= '0;
    end else begin
      state <= next_state;
      add_q <= ram_add;
      in_q  <= ram_in;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_push)
        count <= count + 1'b1;
      else if (do_pop)
        count <= count - 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    ram_read   = 1'b0;
    ram_write  = 1'b0;
    ram_en     = 1'b0;
    ram_add    = add_q;
    ram_in     = in_q;
    pop_valid  = 1'b0;
    pop_data   = '0;
    case (state)
      IDLE: begin
        if (do_pop) begin
          next_state = RD_WAIT;
          ram_read   = 1'b1;
          ram_en     = 1'b1;
          ram_add    = rd_ptr;
        end else if (do_push) begin
          ram_write = 1'b1;
          ram_en    = 1'b1;
          ram_add   = wr_ptr;
          ram_in    = push_data;
        end
      end
      RD_WAIT: begin
        next_state = IDLE;
        // Word read last cycle is forwarded straight from the RAM output.
        if (!rst) begin
          pop_valid = 1'b1;
          pop_data  = ram_out;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
